line_mem_responder: RTL and testbench

- Physical-memory responder for the L2 line interface: the memory side of the protocol that the L2 datapath initiates.
- Accepts one 128-bit line read or write at a time on pmem_address/pmem_wdata, waits a fixed programmable latency, then completes with a single-cycle pmem_resp.
- Backs a line-organised storage array. Used as the synthesizable main memory beneath the L2 and as the bench target for L2 verification.

---
 rtl/cache_types.sv | 16 +
 rtl/line_mem_array.sv | 24 ++
 rtl/line_mem_responder.sv | 106 ++++++++++
 tb/tb_line_mem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared cache/memory types for the L2 line interface
package cache_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] cache_line;
    typedef logic [11:0]  line_index;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } line_mem_state_t;

    localparam int LINE_MEM_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/line_mem_array.sv
// rtl/line_mem_array.sv - single-port line storage, synchronous write, registered read
module line_mem_array
    import cache_types::*;
#(
    parameter int LINE_ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [LINE_ADDR_W-1:0] index,
    input  cache_line              din,
    output cache_line              dout
);

    cache_line mem [2**LINE_ADDR_W];

    // Read is unconditional every cycle; dout reflects contents before any same-edge write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= din;
        end
        dout <= mem[index];
    end

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - fixed-latency line memory responder; LINE_MEM_STATS_EN adds op counters
module line_mem_responder
    import cache_types::*;
#(
    parameter int LATENCY     = LINE_MEM_LATENCY_DEFAULT,
    parameter int LINE_ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [15:0] pmem_address,
    input  cache_line   pmem_wdata,
    output cache_line   pmem_rdata,
    output logic        pmem_resp
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    line_mem_state_t        state;
    logic [7:0]             counter;
    logic [LINE_ADDR_W-1:0] line_q;
    cache_line              wdata_q;
    logic                   is_write_q;

    logic                   commit;
    logic                   array_we;
    logic [LINE_ADDR_W-1:0] array_index;
    cache_line              array_dout;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^pmem_address[3:0];

    assign commit   = (state == BUSY) && (counter == 8'd0);
    // Gated by rst_n so a reset landing on the commit edge still discards the write.
    assign array_we = commit && is_write_q && rst_n;

    // Steering the live address in IDLE lets the registered read settle before a LATENCY=1 commit.
    assign array_index = (state == IDLE) ? pmem_address[LINE_ADDR_W+3:4] : line_q;

    line_mem_array #(
        .LINE_ADDR_W(LINE_ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (array_we),
        .index(array_index),
        .din  (wdata_q),
        .dout (array_dout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= 8'd0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
`ifdef LINE_MEM_STATS_EN
            rd_count   <= 16'd0;
            wr_count   <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pmem_resp <= 1'b0;
                    if (pmem_read || pmem_write) begin
                        line_q     <= pmem_address[LINE_ADDR_W+3:4];
                        wdata_q    <= pmem_wdata;
                        is_write_q <= !pmem_read;
                        counter    <= 8'(LATENCY - 1);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (commit) begin
                        state     <= RESP;
                        pmem_resp <= 1'b1;
                        if (!is_write_q) begin
                            pmem_rdata <= array_dout;
                        end
`ifdef LINE_MEM_STATS_EN
                        if (is_write_q) begin
                            wr_count <= wr_count + 16'd1;
                        end else begin
                            rd_count <= rd_count + 16'd1;
                        end
`endif
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                RESP: begin
                    pmem_resp <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    pmem_resp <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - directed bench for line_mem_responder at LATENCY 4 and 1
module tb_line_mem_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd0, wr0, resp0;
    logic [15:0]  addr0;
    logic [127:0] wdata0, rdata0;
    logic         rd1, wr1, resp1;
    logic [15:0]  addr1;
    logic [127:0] wdata1, rdata1;
`ifdef LINE_MEM_STATS_EN
    logic [15:0]  rdc0, wrc0, rdc1, wrc1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2  = 128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0;
    localparam logic [127:0] DA  = {8{16'hAAAA}};
    localparam logic [127:0] D5  = {8{16'h5555}};
    localparam logic [127:0] DF  = {8{16'hFFFF}};
    localparam logic [127:0] PRE = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] E1  = 128'hE1E1_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] E2  = 128'hE2E2_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    localparam logic [127:0] L1  = 128'hC0FFEE00_11223344_55667788_99AABBCC;
    localparam logic [127:0] L2  = 128'hDEADBEEF_CAFEF00D_0BADF00D_FEEDFACE;

    always #5 clk = ~clk;

    line_mem_responder #(.LATENCY(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pmem_read   (rd0),
        .pmem_write  (wr0),
        .pmem_address(addr0),
        .pmem_wdata  (wdata0),
        .pmem_rdata  (rdata0),
        .pmem_resp   (resp0)
`ifdef LINE_MEM_STATS_EN
        ,
        .rd_count    (rdc0),
        .wr_count    (wrc0)
`endif
    );

    line_mem_responder #(.LATENCY(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .pmem_read   (rd1),
        .pmem_write  (wr1),
        .pmem_address(addr1),
        .pmem_wdata  (wdata1),
        .pmem_rdata  (rdata1),
        .pmem_resp   (resp1)
`ifdef LINE_MEM_STATS_EN
        ,
        .rd_count    (rdc1),
        .wr_count    (wrc1)
`endif
    );

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
    task automatic op(input int sel, input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [127:0] wd, output int lat, output logic [127:0] rdata,
                      output logic resp_after);
        if (sel == 0) begin
            rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = wd;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = wd;
        end
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if ((sel == 0) ? resp0 : resp1) lat = i;
        end
        rdata = (sel == 0) ? rdata0 : rdata1;
        if (sel == 0) begin
            rd0 = 1'b0; wr0 = 1'b0;
        end else begin
            rd1 = 1'b0; wr1 = 1'b0;
        end
        @(negedge clk);
        resp_after = (sel == 0) ? resp0 : resp1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
        rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL reset_resp got=%b exp=0", resp0); end
        n_checks++; if (rdata0 !== 128'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata0); end
        n_checks++; if (resp1 !== 1'b0 || rdata1 !== 128'h0) begin n_fail++; $display("FAIL reset_dut1 resp=%b rdata=%h exp=0/0", resp1, rdata1); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat; logic [127:0] rd; logic ra;
        op(0, 0, 1, 16'h1230, D1, lat, rd, ra);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL wr_latency got=%0d exp=5", lat); end
        n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL wr_resp_width got=%b exp=0", ra); end
        op(0, 1, 0, 16'h1238, '0, lat, rd, ra);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rd_latency got=%0d exp=5", lat); end
        n_checks++; if (rd !== D1) begin n_fail++; $display("FAIL rd_data got=%h exp=%h", rd, D1); end
        op(0, 0, 1, 16'h2000, D2, lat, rd, ra);
        n_checks++; if (rdata0 !== D1) begin n_fail++; $display("FAIL rdata_hold got=%h exp=%h", rdata0, D1); end
    endtask

    task automatic test_held_request();
        int pulses = 0; int t1 = -1; int t2 = -1;
        rd0 = 1'b1; addr0 = 16'h1230;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp0) begin
                pulses++;
                if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
            end
            if (i == 7) rd0 = 1'b0;
        end
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL held_pulses got=%0d exp=2", pulses); end
        n_checks++; if (t1 !== 5 || t2 !== 11) begin n_fail++; $display("FAIL held_timing got=%0d,%0d exp=5,11", t1, t2); end
        n_checks++; if (rdata0 !== D1) begin n_fail++; $display("FAIL held_data got=%h exp=%h", rdata0, D1); end
    endtask

    task automatic test_simultaneous();
        int lat; logic [127:0] rd; logic ra;
        op(0, 0, 1, 16'h0040, DA, lat, rd, ra);
        op(0, 1, 1, 16'h0040, D5, lat, rd, ra);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rw_latency got=%0d exp=5", lat); end
        n_checks++; if (rd !== DA) begin n_fail++; $display("FAIL rw_as_read got=%h exp=%h", rd, DA); end
        op(0, 1, 0, 16'h0040, '0, lat, rd, ra);
        n_checks++; if (rd !== DA) begin n_fail++; $display("FAIL rw_no_write got=%h exp=%h", rd, DA); end
    endtask

    task automatic test_reset_mid_write();
        int lat; int pulses = 0; logic [127:0] rd; logic ra;
        op(0, 0, 1, 16'h5550, PRE, lat, rd, ra);
        wr0 = 1'b1; addr0 = 16'h5550; wdata0 = DF;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; wr0 = 1'b0;
        @(negedge clk);
        n_checks++; if (rdata0 !== 128'h0) begin n_fail++; $display("FAIL midrst_rdata got=%h exp=0", rdata0); end
        if (resp0) pulses++;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp0) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_resp got=%0d pulses exp=0", pulses); end
        op(0, 1, 0, 16'h5550, '0, lat, rd, ra);
        n_checks++; if (rd !== PRE) begin n_fail++; $display("FAIL midrst_discard got=%h exp=%h", rd, PRE); end
    endtask

    task automatic test_index_extremes();
        int lat; logic [127:0] rd; logic ra;
        op(0, 0, 1, 16'hFFF0, E1, lat, rd, ra);
        op(0, 0, 1, 16'h0000, E2, lat, rd, ra);
        op(0, 1, 0, 16'hFFF0, '0, lat, rd, ra);
        n_checks++; if (rd !== E1) begin n_fail++; $display("FAIL idx_top got=%h exp=%h", rd, E1); end
        op(0, 1, 0, 16'h0000, '0, lat, rd, ra);
        n_checks++; if (rd !== E2) begin n_fail++; $display("FAIL idx_zero got=%h exp=%h", rd, E2); end
`ifdef LINE_MEM_STATS_EN
        n_checks++; if (rdc0 !== 16'd3 || wrc0 !== 16'd2) begin n_fail++; $display("FAIL stats_lat4 got=%0d/%0d exp=3/2", rdc0, wrc0); end
`endif
    endtask

    task automatic test_latency1();
        int lat; logic [127:0] rd; logic ra;
        int lats [5];
        logic [127:0] rds [5];
        op(1, 0, 1, 16'h0100, L1, lats[0], rd, ra);
        op(1, 0, 1, 16'h0200, L2, lats[1], rd, ra);
        op(1, 1, 0, 16'h0100, '0, lats[2], rds[2], ra);
        op(1, 1, 0, 16'h0200, '0, lats[3], rds[3], ra);
        op(1, 1, 0, 16'h0100, '0, lats[4], rds[4], ra);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (lats[i] !== 2) begin n_fail++; $display("FAIL lat1_op%0d got=%0d exp=2", i, lats[i]); end
        end
        n_checks++; if (rds[2] !== L1 || rds[4] !== L1) begin n_fail++; $display("FAIL lat1_rd_a got=%h,%h exp=%h", rds[2], rds[4], L1); end
        n_checks++; if (rds[3] !== L2) begin n_fail++; $display("FAIL lat1_rd_b got=%h exp=%h", rds[3], L2); end
        lat = 0;
`ifdef LINE_MEM_STATS_EN
        n_checks++; if (rdc1 !== 16'd3) begin n_fail++; $display("FAIL stats_rd got=%0d exp=3", rdc1); end
        n_checks++; if (wrc1 !== 16'd2) begin n_fail++; $display("FAIL stats_wr got=%0d exp=2", wrc1); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held_request();
        test_simultaneous();
        test_reset_mid_write();
        test_index_extremes();
        test_latency1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
